// File: rtl/eb2b_ctrl.sv
// rtl/eb2b_ctrl.sv - handshake controller for the 2-entry elastic buffer (eb2b_data)
// Optional statistics counters enabled by defining EB2B_CTRL_STATS_EN.
module eb2b_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 t_0_req,
    output logic                 t_0_ack,
    output logic                 i_0_req,
    input  logic                 i_0_ack,
    input  logic                 flush,
    output logic                 en0,
    output logic                 en1,
    output logic                 sel,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] stat_xfer,
    output logic [CNT_WIDTH-1:0] stat_stall,
    input  logic                 stat_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t state, next_state;
    logic   t_fire, i_fire;

    assign t_fire = t_0_req & t_0_ack;
    assign i_fire = i_0_req & i_0_ack;

    always_comb begin
        next_state = EMPTY;
        en0        = 1'b0;
        en1        = 1'b0;
        sel        = 1'b0;
        case (state)
            EMPTY: begin
                next_state = EMPTY;
                if (t_fire) begin
                    en0        = 1'b1;
                    next_state = HALF;
                end
            end
            HALF: begin
                next_state = HALF;
                if (t_fire && i_fire) begin
                    en0 = 1'b1;
                end else if (t_fire) begin
                    en1        = 1'b1;
                    next_state = FULL;
                end else if (i_fire) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                next_state = FULL;
                if (i_fire) begin
                    // Skid entry moves forward into the output register.
                    en0        = 1'b1;
                    sel        = 1'b1;
                    next_state = HALF;
                end
            end
            default: next_state = EMPTY;
        endcase
        if (flush) begin
            next_state = EMPTY;
            en0        = 1'b0;
            en1        = 1'b0;
            sel        = 1'b0;
        end
    end

    // Handshake outputs are registered from next_state so i_0_ack never reaches t_0_ack combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            t_0_ack   <= 1'b0;
            i_0_req   <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            state     <= next_state;
            t_0_ack   <= (next_state != FULL);
            i_0_req   <= (next_state != EMPTY);
            occupancy <= (next_state == FULL) ? 2'd2 :
                         (next_state == HALF) ? 2'd1 : 2'd0;
        end
    end

`ifdef EB2B_CTRL_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] xfer_q, stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else if (stat_clr) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else begin
            if (i_fire && (xfer_q != '1)) begin
                xfer_q <= xfer_q + CNT_ONE;
            end
            if (i_0_req && !i_0_ack && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_ONE;
            end
        end
    end

    assign stat_xfer  = xfer_q;
    assign stat_stall = stall_q;
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign stat_xfer       = '0;
    assign stat_stall      = '0;
`endif

endmodule

// File: tb/tb_eb2b_ctrl.sv
// tb/tb_eb2b_ctrl.sv - self-checking bench for eb2b_ctrl against a queue-based buffer model
module tb_eb2b_ctrl;

    logic       clk;
    logic       reset_n;
    logic       t_0_req;
    logic       t_0_ack;
    logic       i_0_req;
    logic       i_0_ack;
    logic       flush;
    logic       en0;
    logic       en1;
    logic       sel;
    logic [1:0] occupancy;
    logic [3:0] stat_xfer;
    logic [3:0] stat_stall;
    logic       stat_clr;

    eb2b_ctrl #(.CNT_WIDTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .t_0_req    (t_0_req),
        .t_0_ack    (t_0_ack),
        .i_0_req    (i_0_req),
        .i_0_ack    (i_0_ack),
        .flush      (flush),
        .en0        (en0),
        .en1        (en1),
        .sel        (sel),
        .occupancy  (occupancy),
        .stat_xfer  (stat_xfer),
        .stat_stall (stat_stall),
        .stat_clr   (stat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: the buffer is a FIFO of word ids; registered outputs follow its size.
    int q[$];
    int out_log[$];
    int word_ctr = 0;
    bit fresh    = 1'b1;
    int exp_xfer = 0;
    int exp_stall = 0;
    int reg0 = 0;
    int reg1 = 0;
    int m_sz, m_nsz, n_reg0, n_reg1;
    bit m_ack, m_req, m_tf, m_if, m_e0, m_e1, m_es;

    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            fresh     = 1'b1;
            exp_xfer  = 0;
            exp_stall = 0;
            chk("rst_t_0_ack", int'(t_0_ack), 0);
            chk("rst_i_0_req", int'(i_0_req), 0);
            chk("rst_occ", int'(occupancy), 0);
        end else begin
            m_sz  = q.size();
            m_ack = !fresh && (m_sz < 2);
            m_req = (m_sz > 0);
            chk("t_0_ack", int'(t_0_ack), int'(m_ack));
            chk("i_0_req", int'(i_0_req), int'(m_req));
            chk("occupancy", int'(occupancy), m_sz);
            chk("stat_xfer", int'(stat_xfer), exp_xfer);
            chk("stat_stall", int'(stat_stall), exp_stall);
            m_tf = t_0_req && m_ack;
            m_if = m_req && i_0_ack;
            if (flush) begin
                m_e0 = 1'b0;
                m_e1 = 1'b0;
                m_es = 1'b0;
            end else begin
                m_nsz = m_sz - int'(m_if) + int'(m_tf);
                // reg0 reloads whenever the head of the FIFO changes; a newcomer landing second goes to reg1
                m_e0 = (m_nsz > 0) && ((m_sz == 0) || m_if);
                m_es = m_e0 && m_if && (m_sz == 2);
                m_e1 = m_tf && (m_nsz == 2);
            end
            chk("en0", int'(en0), int'(m_e0));
            chk("en1", int'(en1), int'(m_e1));
            chk("sel", int'(sel), int'(m_es));
            if (m_if) begin
                chk("out_data", reg0, q[0]);
                out_log.push_back(reg0);
                void'(q.pop_front());
            end
            n_reg0 = reg0;
            n_reg1 = reg1;
            if (en0) n_reg0 = sel ? reg1 : word_ctr;
            if (en1) n_reg1 = word_ctr;
            reg0 = n_reg0;
            reg1 = n_reg1;
            if (flush) q.delete();
            else if (m_tf) q.push_back(word_ctr);
            if (m_tf) word_ctr++;
`ifdef EB2B_CTRL_STATS_EN
            if (stat_clr) begin
                exp_xfer  = 0;
                exp_stall = 0;
            end else begin
                if (m_if && exp_xfer < 15) exp_xfer++;
                if (m_req && !i_0_ack && exp_stall < 15) exp_stall++;
            end
`endif
            fresh = 1'b0;
        end
    end

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic tr, input logic ia);
        t_0_req = tr;
        i_0_ack = ia;
    endtask

    int base, l0;

    initial begin
        reset_n = 1'b0; t_0_req = 1'b0; i_0_ack = 1'b0; flush = 1'b0; stat_clr = 1'b0;
        #12;
        chk("reset_t_0_ack", int'(t_0_ack), 0);
        chk("reset_i_0_req", int'(i_0_req), 0);
        chk("reset_occ", int'(occupancy), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("ack_before_first_edge", int'(t_0_ack), 0);
        drive(0, 1); edge1();
        chk("ack_after_first_edge", int'(t_0_ack), 1);
        chk("req_before_fire", int'(i_0_req), 0);

        // Streaming: 8 words at one per cycle.
        base = word_ctr; l0 = out_log.size();
        drive(1, 1); edge1();
        chk("req_after_first_fire", int'(i_0_req), 1);
        repeat (7) edge1();
        chk("stream_7_delivered", out_log.size() - l0, 7);
        drive(0, 1); edge1();
        chk("stream_8_delivered", out_log.size() - l0, 8);
        for (int k = 0; k < 8; k++) chk("stream_order", out_log[l0 + k], base + k);
        repeat (2) edge1();

        // Fill while stalled, then release.
        base = word_ctr; l0 = out_log.size();
        drive(1, 0); edge1();
        chk("fill_occ1", int'(occupancy), 1);
        edge1();
        chk("fill_occ2", int'(occupancy), 2);
        chk("fill_ack_low", int'(t_0_ack), 0);
        edge1();
        chk("fill_held_occ", int'(occupancy), 2);
        drive(1, 1); #1;
        chk("drain_sel_full", int'(sel), 1);
        edge1();
        chk("drain_sel_half", int'(sel), 0);
        chk("drain_en0_half", int'(en0), 1);
        edge1();
        drive(0, 1); edge1();
        drive(0, 0);
        chk("fill_count", out_log.size() - l0, 3);
        for (int k = 0; k < 3; k++) chk("fill_order", out_log[l0 + k], base + k);
        edge1();

        // Random traffic against the model.
        base = word_ctr; l0 = out_log.size();
        for (int n = 0; n < 10000; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            edge1();
        end
        drive(0, 1); repeat (3) edge1();
        chk("rand_drained", q.size(), 0);
        chk("rand_no_loss", out_log.size() - l0, word_ctr - base);

        // Flush while full, with both sides willing.
        drive(1, 0); repeat (2) edge1();
        chk("pre_flush_occ", int'(occupancy), 2);
        drive(1, 1); flush = 1'b1; #1;
        chk("flush_en0", int'(en0), 0);
        chk("flush_en1", int'(en1), 0);
        edge1();
        flush = 1'b0; drive(0, 0);
        chk("post_flush_occ", int'(occupancy), 0);
        chk("post_flush_req", int'(i_0_req), 0);
        chk("post_flush_ack", int'(t_0_ack), 1);
        edge1();

        // Asynchronous reset while HALF.
        drive(1, 0); edge1();
        drive(0, 0);
        chk("pre_rst_occ", int'(occupancy), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_t_0_ack", int'(t_0_ack), 0);
        chk("async_i_0_req", int'(i_0_req), 0);
        chk("async_occ", int'(occupancy), 0);
        edge1();
        reset_n = 1'b1;
        base = word_ctr; l0 = out_log.size();
        drive(1, 1); repeat (4) edge1();
        drive(0, 1); repeat (3) edge1();
        chk("restart_count", out_log.size() - l0, 3);
        for (int k = 0; k < 3; k++) chk("restart_order", out_log[l0 + k], base + k);

        // Statistics counters.
        drive(0, 0); stat_clr = 1'b1; edge1();
        stat_clr = 1'b0;
        drive(1, 1); repeat (20) edge1();
        drive(0, 1); repeat (2) edge1();
        drive(1, 0); edge1();
        drive(0, 0); repeat (3) edge1();
`ifdef EB2B_CTRL_STATS_EN
        chk("stat_xfer_sat", int'(stat_xfer), 15);
        chk("stat_stall_3", int'(stat_stall), 3);
`else
        chk("stat_xfer_off", int'(stat_xfer), 0);
        chk("stat_stall_off", int'(stat_stall), 0);
`endif
        drive(0, 1); stat_clr = 1'b1; #1;
        chk("clr_with_fire_req", int'(i_0_req), 1);
        edge1();
        stat_clr = 1'b0; drive(0, 0);
        chk("stat_xfer_clr", int'(stat_xfer), 0);
        chk("stat_stall_clr", int'(stat_stall), 0);
        edge1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
